// File: rtl/jtpopeye_pkg.sv
// Shared types and defaults for the Popeye sprite DMA: state encoding,
// default source window and the registered object-RAM write record.
package jtpopeye_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_COPY,
    ST_DRAIN,
    ST_DONE
  } dma_st_e;

  localparam logic [10:0] DMA_SRC_BASE = 11'h400;
  localparam logic [9:0]  DMA_LEN      = 10'd512;

  typedef struct packed {
    logic       we;
    logic [9:0] addr;
    logic [7:0] din;
  } obj_wr_t;

  // Source address wraps inside the 2 KB main-RAM window
  function automatic logic [10:0] dma_ram_addr(input logic [10:0] base,
                                               input logic [9:0]  cnt);
    return base + {1'b0, cnt};
  endfunction

endpackage

// File: rtl/jtpopeye_dma_fsm.sv
// Bus-arbitration state machine and byte counter for the sprite DMA.
// All outputs are registered and advance only on cen.
module jtpopeye_dma_fsm
  import jtpopeye_pkg::*;
#(
  parameter logic [9:0] LEN = DMA_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       lvbl_i,
  input  logic       dma_en_i,
  input  logic       busak_n_i,
  output dma_st_e    st_o,
  output logic [9:0] cnt_o,
  output logic       bus_req_o,
  output logic       dmcs_o,
  output logic       busy_o
);

  dma_st_e    st_q;
  logic [9:0] cnt_q;
  logic       bus_req_q;
  logic       dmcs_q;
  logic       busy_q;
  logic       lvbl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      bus_req_q <= 1'b0;
      dmcs_q    <= 1'b0;
      busy_q    <= 1'b0;
      lvbl_q    <= 1'b1;
    end else if (cen) begin
      lvbl_q <= lvbl_i;
      case (st_q)
        ST_IDLE: begin
          if (lvbl_q && !lvbl_i && dma_en_i) begin
            st_q      <= ST_REQ;
            bus_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!busak_n_i) begin
            st_q   <= ST_COPY;
            dmcs_q <= 1'b1;
          end
        end
        ST_COPY: begin
          // Losing the bus freezes the counter so the same address is re-read
          if (!busak_n_i) begin
            if (cnt_q == LEN - 10'd1) st_q  <= ST_DRAIN;
            else                      cnt_q <= cnt_q + 10'd1;
          end
        end
        ST_DRAIN: begin
          if (!busak_n_i) begin
            st_q      <= ST_DONE;
            bus_req_q <= 1'b0;
            dmcs_q    <= 1'b0;
            cnt_q     <= '0;
          end
        end
        ST_DONE: begin
          st_q   <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign st_o      = st_q;
  assign cnt_o     = cnt_q;
  assign bus_req_o = bus_req_q;
  assign dmcs_o    = dmcs_q;
  assign busy_o    = busy_q;

endmodule

// File: rtl/jtpopeye_dma.sv
// Popeye sprite DMA: copies LEN bytes from main RAM into object RAM at the
// start of vertical blank while holding the Z80 off the bus.
module jtpopeye_dma
  import jtpopeye_pkg::*;
#(
  parameter logic [10:0] SRC_BASE = DMA_SRC_BASE,
  parameter logic [9:0]  LEN      = DMA_LEN
) (
  input  logic        rst_n,
  input  logic        clk,
  input  logic        cen,
  input  logic        LVBL,
  input  logic        dma_en,
  input  logic        busak_n,
  output logic        bus_req,
  output logic        DMCS,
  output logic [10:0] ram_addr,
  input  logic [7:0]  ram_dout,
  output logic [9:0]  obj_addr,
  output logic [7:0]  obj_din,
  output logic        obj_we,
  output logic        busy
);

  dma_st_e    st;
  logic [9:0] cnt;
  logic       rd;
  obj_wr_t    wr_q;
  obj_wr_t    wr_d;

  jtpopeye_dma_fsm #(
    .LEN (LEN)
  ) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .lvbl_i    (LVBL),
    .dma_en_i  (dma_en),
    .busak_n_i (busak_n),
    .st_o      (st),
    .cnt_o     (cnt),
    .bus_req_o (bus_req),
    .dmcs_o    (DMCS),
    .busy_o    (busy)
  );

  // A read is consumed only on a cycle where the CPU is still off the bus
  assign rd = (st == ST_COPY) && !busak_n;

  always_comb begin
    wr_d    = wr_q;
    wr_d.we = rd;
    if (rd) begin
      wr_d.addr = cnt;
      wr_d.din  = ram_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   wr_q <= '0;
    else if (cen) wr_q <= wr_d;
  end

  assign ram_addr = dma_ram_addr(SRC_BASE, cnt);
  assign obj_we   = wr_q.we;
  assign obj_addr = wr_q.addr;
  assign obj_din  = wr_q.din;

endmodule

// File: doc/jtpopeye_dma.md
JTPOPEYE_DMA -- requirements
Module: jtpopeye_dma

Interface
REQ-001 Parameter SRC_BASE, default 11'h400: first main-RAM word address copied.
REQ-002 Parameter LEN, default 10'd512: number of bytes copied per frame (1..1023).
REQ-003 rst_n  in  1  async active-low reset.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 cen  in  1  clock enable, same as cpu_cen; all state advances only when cen=1.
REQ-006 LVBL  in  1  vertical blank, active low.
REQ-007 dma_en  in  1  when 0, no new transfer starts.
REQ-008 busak_n  in  1  Z80 bus acknowledge, active low.
REQ-009 bus_req  out  1  Z80 bus request, active high; drives BUSRQ_n inverted.
REQ-010 DMCS  out  1  forces main-RAM chip select while DMA owns the bus.
REQ-011 ram_addr  out  11  main-RAM address during DMA.
REQ-012 ram_dout  in  8  main-RAM read data, valid one cen cycle after ram_addr.
REQ-013 obj_addr  out  10  object-RAM write address.
REQ-014 obj_din  out  8  object-RAM write data.
REQ-015 obj_we  out  1  object-RAM write strobe, one cen cycle per byte.
REQ-016 busy  out  1  high from request until DONE is left.

Function
REQ-017 LVBL is sampled on cen; a start event is a 1->0 transition of the sampled LVBL.
REQ-018 States: IDLE, REQ, COPY, DRAIN, DONE.
REQ-019 IDLE->REQ on a start event with dma_en=1; bus_req=1 from the cen cycle after the event.
REQ-020 REQ->COPY on the first cen cycle with busak_n=0; DMCS=1 from entry to COPY until DRAIN exits.
REQ-021 COPY: ram_addr = SRC_BASE + cnt (11-bit wrap); cnt increments once per cen cycle from 0.
REQ-022 Write pipeline: obj_we=1, obj_addr=cnt delayed one cen cycle, obj_din=ram_dout, exactly one cycle after each read address.
REQ-023 COPY->DRAIN when cnt reaches LEN-1; DRAIN issues the final write and goes to DONE.
REQ-024 DONE: bus_req=0, DMCS=0, obj_we=0; DONE->IDLE on the next cen cycle.
REQ-025 busak_n returning to 1 during COPY/DRAIN: freeze cnt, suppress obj_we, hold the pending datum, keep bus_req=1, resume when busak_n=0; no byte is lost or duplicated.
REQ-026 Start events while not IDLE are ignored; no queueing.
REQ-027 dma_en falling mid-transfer does not abort; it only blocks the next start.
REQ-028 obj_we never asserted while DMCS=0; ram_addr is don't-care when DMCS=0 but holds SRC_BASE.
REQ-029 When cen=0, all outputs hold their values.

Reset
REQ-030 On rst_n=0, immediately (asynchronously): state=IDLE, cnt=0, bus_req=0, DMCS=0, obj_we=0, busy=0, obj_addr=0, obj_din=0, ram_addr=SRC_BASE, LVBL sample=1.
REQ-031 Reset mid-transfer releases the bus the same cycle; the partial copy is not resumed after reset.

Structure
REQ-032 State encoding and SRC_BASE/LEN defaults live in a shared jtpopeye_pkg package.
REQ-033 A single sub-module, jtpopeye_dma_fsm (state and counter), is permitted; the datapath stays in the top.

Verification
REQ-034 Default parameters, ram[i]=i[7:0]; LVBL 1->0, busak_n low 2 cen cycles after bus_req -> 512 obj_we pulses, obj[k]=(0x400+k)[7:0], bus_req low after the final write.
REQ-035 busak_n held 1 for 20 cen cycles after bus_req -> no obj_we and DMCS=0 until ack, then a full copy.
REQ-036 busak_n raised for 5 cen cycles at cnt=100 -> obj_we gap of 5 cycles, obj[100..102] still correct, total 512 writes.
REQ-037 Second LVBL falling edge during COPY -> ignored; exactly 512 writes, busy drops once.
REQ-038 rst_n low at cnt=300 -> bus_req=0 and obj_we=0 within the same clock; after release, IDLE until the next LVBL edge.
REQ-039 dma_en=0 at LVBL falling edge -> bus_req stays 0 for the whole frame; LEN=1 -> exactly one write, obj[0]=ram[SRC_BASE].
